// File: rtl/dram_sim_resp_buffer_if.sv
// Completion-side bus of the DRAM sim response buffer.
// Carries the simulator push strobe plus the R and B output channels.
interface dram_sim_resp_buffer_if #(
    parameter int IdWidth   = 4,
    parameter int DataWidth = 64
);
    logic                 resp_valid_i;
    logic                 resp_is_write_i;
    logic [IdWidth-1:0]   resp_id_i;
    logic [DataWidth-1:0] resp_data_i;
    logic                 resp_last_i;
    logic                 r_valid_o;
    logic                 r_ready_i;
    logic [IdWidth-1:0]   r_id_o;
    logic [DataWidth-1:0] r_data_o;
    logic                 r_last_o;
    logic                 b_valid_o;
    logic                 b_ready_i;
    logic [IdWidth-1:0]   b_id_o;

    modport slave (
        input  resp_valid_i, resp_is_write_i, resp_id_i,
        input  resp_data_i, resp_last_i, r_ready_i, b_ready_i,
        output r_valid_o, r_id_o, r_data_o, r_last_o,
        output b_valid_o, b_id_o
    );

    modport master (
        output resp_valid_i, resp_is_write_i, resp_id_i,
        output resp_data_i, resp_last_i, r_ready_i, b_ready_i,
        input  r_valid_o, r_id_o, r_data_o, r_last_o,
        input  b_valid_o, b_id_o
    );
endinterface

// File: rtl/dram_sim_resp_buffer.sv
// Buffers DRAM-sim completions into R/B FIFOs and stalls the clock engine.
// Define DRAM_SIM_RESP_STATS_EN to add saturating pop/stall counters.
module dram_sim_resp_buffer #(
    parameter int IdWidth     = 4,
    parameter int DataWidth   = 64,
    parameter int RDepth      = 16,
    parameter int BDepth      = 8,
    parameter int StallMargin = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    dram_sim_resp_buffer_if.slave  bus,
    output logic                   sim_stall_o,
    output logic                   overflow_o
`ifdef DRAM_SIM_RESP_STATS_EN
   ,output logic [31:0]            stat_rbeats_o,
    output logic [31:0]            stat_backs_o,
    output logic [31:0]            stat_stall_cycles_o
`endif
);
    localparam int RAW = $clog2(RDepth);
    localparam int RCW = RAW + 1;
    localparam int BAW = $clog2(BDepth);
    localparam int BCW = BAW + 1;
    localparam logic [RCW-1:0] RDepthC  = RCW'(RDepth);
    localparam logic [RCW-1:0] RMarginC = RCW'(StallMargin);
    localparam logic [BCW-1:0] BDepthC  = BCW'(BDepth);
    localparam logic [BCW-1:0] BMarginC = BCW'(StallMargin);

    logic [IdWidth-1:0]   r_id_mem_q   [RDepth];
    logic [DataWidth-1:0] r_data_mem_q [RDepth];
    logic [RDepth-1:0]    r_last_mem_q;
    logic [IdWidth-1:0]   b_id_mem_q   [BDepth];

    logic [RAW-1:0] r_wr_q, r_rd_q;
    logic [BAW-1:0] b_wr_q, b_rd_q;
    logic [RCW-1:0] r_count_q, r_count_d;
    logic [BCW-1:0] b_count_q, b_count_d;
    logic           overflow_q, overflow_d;

    logic r_push, r_pop, r_acc, r_full;
    logic b_push, b_pop, b_acc, b_full;

    assign r_push = bus.resp_valid_i & ~bus.resp_is_write_i;
    assign b_push = bus.resp_valid_i &  bus.resp_is_write_i;
    assign r_full = (r_count_q == RDepthC);
    assign b_full = (b_count_q == BDepthC);
    assign r_pop  = bus.r_valid_o & bus.r_ready_i;
    assign b_pop  = bus.b_valid_o & bus.b_ready_i;
    // A pop in the same cycle frees the slot the push needs.
    assign r_acc  = r_push & (~r_full | r_pop);
    assign b_acc  = b_push & (~b_full | b_pop);

    always_comb begin
        r_count_d = r_count_q;
        unique case ({r_acc, r_pop})
            2'b10:   r_count_d = r_count_q + RCW'(1);
            2'b01:   r_count_d = r_count_q - RCW'(1);
            default: r_count_d = r_count_q;
        endcase
    end

    always_comb begin
        b_count_d = b_count_q;
        unique case ({b_acc, b_pop})
            2'b10:   b_count_d = b_count_q + BCW'(1);
            2'b01:   b_count_d = b_count_q - BCW'(1);
            default: b_count_d = b_count_q;
        endcase
    end

    assign overflow_d = overflow_q | (r_push & ~r_acc)
                                   | (b_push & ~b_acc);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_q     <= '0;
            r_rd_q     <= '0;
            b_wr_q     <= '0;
            b_rd_q     <= '0;
            r_count_q  <= '0;
            b_count_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (r_acc) r_wr_q <= r_wr_q + RAW'(1);
            if (r_pop) r_rd_q <= r_rd_q + RAW'(1);
            if (b_acc) b_wr_q <= b_wr_q + BAW'(1);
            if (b_pop) b_rd_q <= b_rd_q + BAW'(1);
            r_count_q  <= r_count_d;
            b_count_q  <= b_count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is cleared so every output reads 0 straight out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RDepth; i++) begin
                r_id_mem_q[i]   <= '0;
                r_data_mem_q[i] <= '0;
            end
            r_last_mem_q <= '0;
            for (int i = 0; i < BDepth; i++) begin
                b_id_mem_q[i] <= '0;
            end
        end else begin
            if (r_acc) begin
                r_id_mem_q[r_wr_q]   <= bus.resp_id_i;
                r_data_mem_q[r_wr_q] <= bus.resp_data_i;
                r_last_mem_q[r_wr_q] <= bus.resp_last_i;
            end
            if (b_acc) begin
                b_id_mem_q[b_wr_q] <= bus.resp_id_i;
            end
        end
    end

    assign bus.r_valid_o = (r_count_q != '0);
    assign bus.r_id_o    = r_id_mem_q[r_rd_q];
    assign bus.r_data_o  = r_data_mem_q[r_rd_q];
    assign bus.r_last_o  = r_last_mem_q[r_rd_q];
    assign bus.b_valid_o = (b_count_q != '0);
    assign bus.b_id_o    = b_id_mem_q[b_rd_q];
    assign overflow_o    = overflow_q;

    assign sim_stall_o = ((RDepthC - r_count_q) <= RMarginC)
                       | ((BDepthC - b_count_q) <= BMarginC);

`ifdef DRAM_SIM_RESP_STATS_EN
    logic [31:0] st_r_q, st_b_q, st_s_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_r_q <= '0;
            st_b_q <= '0;
            st_s_q <= '0;
        end else begin
            if (r_pop && st_r_q != '1) st_r_q <= st_r_q + 32'd1;
            if (b_pop && st_b_q != '1) st_b_q <= st_b_q + 32'd1;
            if (sim_stall_o && st_s_q != '1) st_s_q <= st_s_q + 32'd1;
        end
    end

    assign stat_rbeats_o       = st_r_q;
    assign stat_backs_o        = st_b_q;
    assign stat_stall_cycles_o = st_s_q;
`endif
endmodule

// File: tb/tb_dram_sim_resp_buffer.sv
// Directed bench for dram_sim_resp_buffer.
// Define DRAM_SIM_RESP_STATS_EN to also exercise the stat counters.
module tb_dram_sim_resp_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall, ovf;
    int   total = 0;
    int   bad   = 0;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] d;
        logic        l;
    } rent_t;

    rent_t      rq[$];
    logic [3:0] bq[$];

    dram_sim_resp_buffer_if #(.IdWidth(4), .DataWidth(64)) bus ();

`ifdef DRAM_SIM_RESP_STATS_EN
    logic [31:0] st_r, st_b, st_s;
`endif

    dram_sim_resp_buffer #(
        .IdWidth(4), .DataWidth(64), .RDepth(16),
        .BDepth(8), .StallMargin(2)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus),
        .sim_stall_o(stall),
        .overflow_o(ovf)
`ifdef DRAM_SIM_RESP_STATS_EN
       ,.stat_rbeats_o(st_r),
        .stat_backs_o(st_b),
        .stat_stall_cycles_o(st_s)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, got timeout want finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rpush(input logic [3:0] id, input logic [63:0] d,
                         input logic l);
        bus.resp_valid_i    = 1'b1;
        bus.resp_is_write_i = 1'b0;
        bus.resp_id_i       = id;
        bus.resp_data_i     = d;
        bus.resp_last_i     = l;
        tick();
        bus.resp_valid_i    = 1'b0;
    endtask

    task automatic bpush(input logic [3:0] id);
        bus.resp_valid_i    = 1'b1;
        bus.resp_is_write_i = 1'b1;
        bus.resp_id_i       = id;
        bus.resp_data_i     = 64'hFFFF;
        bus.resp_last_i     = 1'b1;
        tick();
        bus.resp_valid_i    = 1'b0;
    endtask

    task automatic drain_r(input int n);
        rent_t e;
        bus.r_ready_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            e = rq.pop_front();
            chk("drain_v", bus.r_valid_o, 1);
            chk("drain_d", bus.r_data_o, e.d);
            chk("drain_id", bus.r_id_o, e.id);
            chk("drain_l", bus.r_last_o, e.l);
            tick();
        end
        bus.r_ready_i = 1'b0;
        chk("drain_empty", bus.r_valid_o, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rq.delete();
        bq.delete();
    endtask

    initial begin
        rent_t e;
        bus.resp_valid_i    = 1'b0;
        bus.resp_is_write_i = 1'b0;
        bus.resp_id_i       = '0;
        bus.resp_data_i     = '0;
        bus.resp_last_i     = 1'b0;
        bus.r_ready_i       = 1'b0;
        bus.b_ready_i       = 1'b0;
        tick();
        do_reset();

        for (int k = 0; k < 10; k++) begin
            chk("idle_flags", {bus.r_valid_o, bus.b_valid_o, stall,
                               ovf, bus.r_last_o}, 0);
            tick();
        end
        chk("idle_rdata", bus.r_data_o, 0);
        chk("idle_ids", {bus.r_id_o, bus.b_id_o}, 0);

        bus.r_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.resp_valid_i    = 1'b1;
            bus.resp_is_write_i = 1'b0;
            bus.resp_id_i       = 4'd3;
            bus.resp_data_i     = 64'h10 + 64'(i);
            bus.resp_last_i     = (i == 3);
            if (i == 0) begin
                chk("burst_nobypass", bus.r_valid_o, 0);
            end else begin
                chk("burst_v", bus.r_valid_o, 1);
                chk("burst_d", bus.r_data_o, 64'h10 + 64'(i - 1));
                chk("burst_l", bus.r_last_o, 0);
                chk("burst_id", bus.r_id_o, 3);
            end
            tick();
        end
        bus.resp_valid_i = 1'b0;
        chk("burst_d3", bus.r_data_o, 64'h13);
        chk("burst_l3", bus.r_last_o, 1);
        tick();
        bus.r_ready_i = 1'b0;
        chk("burst_empty", bus.r_valid_o, 0);

        for (int i = 0; i < 14; i++) begin
            rpush(4'd1, 64'(i + 1), 1'b0);
            rq.push_back('{4'd1, 64'(i + 1), 1'b0});
            chk("stall_ramp", stall, (i == 13));
        end
        bus.r_ready_i = 1'b1;
        chk("stall_hold", stall, 1);
        tick();
        void'(rq.pop_front());
        bus.r_ready_i = 1'b0;
        chk("stall_release", stall, 0);

        for (int i = 0; i < 3; i++) begin
            rpush(4'd2, 64'h100 + 64'(i), (i == 2));
            rq.push_back('{4'd2, 64'h100 + 64'(i), (i == 2)});
        end
        chk("full_stall", stall, 1);
        chk("full_noovf", ovf, 0);
        rpush(4'd9, 64'hDEAD, 1'b1);
        chk("ovf_set", ovf, 1);
        tick();
        chk("ovf_sticky", ovf, 1);
        drain_r(16);
        chk("ovf_after_drain", ovf, 1);
        chk("stall_after_drain", stall, 0);

        rpush(4'd4, 64'h55, 1'b0);
        bpush(4'd7);
        chk("pre_rst_r", bus.r_valid_o, 1);
        chk("pre_rst_b", bus.b_valid_o, 1);
        do_reset();
        chk("rst_flags", {bus.r_valid_o, bus.b_valid_o, stall, ovf}, 0);

        for (int i = 0; i < 16; i++) begin
            rpush(4'd5, 64'h200 + 64'(i), 1'b0);
            rq.push_back('{4'd5, 64'h200 + 64'(i), 1'b0});
        end
        bus.r_ready_i = 1'b1;
        chk("fullpop_head", bus.r_data_o, 64'h200);
        rpush(4'd6, 64'h300, 1'b1);
        bus.r_ready_i = 1'b0;
        void'(rq.pop_front());
        rq.push_back('{4'd6, 64'h300, 1'b1});
        chk("fullpop_noovf", ovf, 0);
        drain_r(16);
        chk("fullpop_noovf2", ovf, 0);

        bpush(4'd1);
        rpush(4'd5, 64'hA0, 1'b0);
        bpush(4'd2);
        rpush(4'd5, 64'hA1, 1'b1);
        bpush(4'd3);
        rq.push_back('{4'd5, 64'hA0, 1'b0});
        rq.push_back('{4'd5, 64'hA1, 1'b1});
        bq.push_back(4'd1);
        bq.push_back(4'd2);
        bq.push_back(4'd3);
        for (int k = 0; k < 20 && bq.size() > 0; k++) begin
            bus.b_ready_i = (k % 2 == 1);
            chk("b_valid", bus.b_valid_o, 1);
            chk("b_id", bus.b_id_o, 64'(bq[0]));
            tick();
            if (bus.b_ready_i) void'(bq.pop_front());
        end
        bus.b_ready_i = 1'b0;
        chk("b_drained", 64'(bq.size()), 0);
        chk("b_empty", bus.b_valid_o, 0);
        drain_r(2);

        bpush(4'd4);
        rpush(4'd8, 64'hBB, 1'b1);
        chk("mid_rst_pre", {bus.r_valid_o, bus.b_valid_o}, 2'b11);
        do_reset();
        chk("mid_rst_post", {bus.r_valid_o, bus.b_valid_o, stall}, 0);

`ifdef DRAM_SIM_RESP_STATS_EN
        for (int i = 0; i < 14; i++) rpush(4'd1, 64'(i), 1'b0);
        for (int i = 0; i < 6; i++) tick();
        bus.r_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bus.r_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) bpush(4'(i));
        bus.b_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        bus.b_ready_i = 1'b0;
        chk("stat_r", st_r, 5);
        chk("stat_b", st_b, 3);
        chk("stat_s", st_s, 7);
        do_reset();
        chk("stat_rst", {st_r, st_b, st_s}, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dram_sim_resp_buffer.md
Name: dram_sim_resp_buffer

Overview:
- RTL-side receiver for completions returned by the DRAM simulation model after each engine tick.
- Buffers read data beats and write acknowledgements in separate FIFOs and presents them as AXI-style R and B channels.
- Drives a stall output back to the clock engine so simulator time is not advanced while buffers are near full.

Parameters:
- IdWidth, 4, width of transaction ID
- DataWidth, 64, width of read data beat
- RDepth, 16, read-beat FIFO depth (power of two, >=4)
- BDepth, 8, write-response FIFO depth (power of two, >=4)
- StallMargin, 2, free entries reserved for completions already produced within one engine tick

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- resp_valid_i  in  1  simulator completion strobe, one completion per cycle max, no backpressure
- resp_is_write_i  in  1  1 = write ack, 0 = read beat
- resp_id_i  in  IdWidth  transaction ID
- resp_data_i  in  DataWidth  read data (ignored for writes)
- resp_last_i  in  1  last read beat (ignored for writes)
- r_valid_o  out  1  read beat available
- r_ready_i  in  1  consumer accepts read beat
- r_id_o  out  IdWidth  read ID
- r_data_o  out  DataWidth  read data
- r_last_o  out  1  last beat
- b_valid_o  out  1  write ack available
- b_ready_i  in  1  consumer accepts write ack
- b_id_o  out  IdWidth  write ID
- sim_stall_o  out  1  engine must not advance simulator time this cycle
- overflow_o  out  1  sticky: a completion was dropped

Behaviour:
- Reset (rst_i high at clk_i edge): both FIFOs emptied, pointers and counts 0; all outputs 0, overflow_o cleared. Reset mid-transfer discards buffered entries, no pops reported.
- Push: resp_valid_i=1 writes {id,data,last} to the R FIFO when resp_is_write_i=0, or {id} to the B FIFO when 1. Exactly one FIFO per cycle.
- Latency: an entry pushed at edge N is visible on the *_valid_o outputs from cycle N+1. There is no same-cycle bypass when empty.
- Pop: the handshake is valid&ready at the edge. The head is removed and the next entry appears in the following cycle. Outputs are held stable while valid&!ready.
- Ordering: FIFO order within each channel. No ordering relation between R and B.
- Full with simultaneous pop: push and pop on the same FIFO in the same cycle are both accepted; count unchanged.
- Full without pop: the push is dropped, FIFO contents are unchanged, and overflow_o rises the next cycle and stays high until reset.
- Empty: valid_o is 0 and data outputs hold their last value (don't care).
- Pointer wrap: pointers are log2(Depth) bits and wrap naturally. count is log2(Depth)+1 bits, range 0..Depth.
- Stall: sim_stall_o = (RDepth - r_count <= StallMargin) OR (BDepth - b_count <= StallMargin). It is a combinational function of registered counts only, with no input-to-output path. It deasserts the cycle after a pop raises free space above StallMargin.
- sim_stall_o is 0 during and immediately after reset.

Optional Feature:
- Macro DRAM_SIM_RESP_STATS_EN adds outputs stat_rbeats_o, stat_backs_o and stat_stall_cycles_o, each 32 bits, saturating at 0xFFFFFFFF.
  - stat_rbeats_o counts accepted R pops.
  - stat_backs_o counts accepted B pops.
  - stat_stall_cycles_o counts cycles with sim_stall_o=1.
  - All three clear on reset.
- Without the macro, the ports are absent and no counter logic is built.

Test Plan:
- Reset then idle: all outputs 0 for 10 cycles, sim_stall_o=0.
- Burst of 4 read beats (id=3, data 0x10..0x13, last on beat 4) with r_ready_i=1: r_valid_o from the cycle after the first push, data in order, r_last_o only on 0x13, FIFO empty after.
- r_ready_i=0, push 14 beats with RDepth=16 and StallMargin=2: sim_stall_o=1 the cycle after the 14th push. One pop drops it to 0 the following cycle.
- Fill R FIFO to 16, push a 17th with no pop: beat dropped, overflow_o=1 and sticky, the 16 original beats drain intact. Repeat the full-FIFO push with a same-cycle pop: accepted, no overflow.
- Interleaved write acks ids 1,2,3 and read beats with b_ready_i toggling 1/0: B order 1,2,3 and b_id_o stable while stalled. Asserting rst_i with entries present empties both FIFOs in the next cycle.
- With DRAM_SIM_RESP_STATS_EN: 5 R pops, 3 B pops and 7 stall cycles give stat counters of 5, 3 and 7; all read 0 after reset.
